// File: rtl/cpu_debug_mem_pkg.sv
// Shared types and constants for the JTAG debug memory master: FSM states,
// jdo field positions, default error word and the command decoder.
package cpu_debug_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    localparam int unsigned JDO_WR_BIT            = 35;
    localparam int unsigned JDO_RD_AFTER_LOAD_BIT = 34;
    localparam int unsigned JDO_DATA_MSB          = 34;
    localparam int unsigned JDO_DATA_LSB          = 3;
    localparam int unsigned JDO_ADDR_LSB          = 2;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

    typedef struct packed {
        logic accept;
        logic load_addr;
        logic start_rd;
        logic start_wr;
    } cmd_t;

    // Resolves simultaneous pulses: ocimem_a wins over ocimem_b, which wins over no_action.
    function automatic cmd_t decode_cmd(
        input logic act_a,
        input logic act_b,
        input logic no_act_a,
        input logic wr_bit,
        input logic rd_after_load_bit
    );
        cmd_t cmd;
        cmd = '0;
        if (act_a) begin
            cmd.accept    = 1'b1;
            cmd.load_addr = 1'b1;
            cmd.start_rd  = rd_after_load_bit;
        end else if (act_b) begin
            cmd.accept   = 1'b1;
            cmd.start_wr = wr_bit;
            cmd.start_rd = !wr_bit;
        end else if (no_act_a) begin
            cmd.accept   = 1'b1;
            cmd.start_rd = 1'b1;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/cpu_debug_mem_if.sv
// Avalon-MM single-word master bus used by the debug memory master.
interface cpu_debug_mem_if #(
    parameter int unsigned ADDR_W = 24
);
    logic [ADDR_W+1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        output avm_write,
        output avm_writedata,
        output avm_byteenable,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        input  avm_write,
        input  avm_writedata,
        input  avm_byteenable,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/cpu_debug_mem_timeout.sv
// Consecutive-stall counter: counts enabled cycles, clear reloads zero, and
// expired flags the cycle on which the LIMIT-th stall cycle is being counted.
module cpu_debug_mem_timeout #(
    parameter int unsigned LIMIT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // NOTE: default assignment first so every path drives count_d and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 16'd1;
        end
    end

    assign expired = en && (count_q == LAST);

    // NOTE: non-blocking assignments for state so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/cpu_debug_mem_master.sv
// JTAG monitor memory master: decodes debug-slave commands into single-word Avalon reads/writes.
// Optional CPU_DEBUG_MEM_ACCESS_COUNT_EN adds a saturating access_count of completed transfers.
module cpu_debug_mem_master
    import cpu_debug_mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = 24,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [37:0]            jdo,
    input  logic                   take_action_ocimem_a,
    input  logic                   take_action_ocimem_b,
    input  logic                   take_no_action_ocimem_a,
    cpu_debug_mem_if.master        avm,
    output logic [31:0]            MonDReg,
    output logic                   monitor_ready,
    output logic                   monitor_error
`ifdef CPU_DEBUG_MEM_ACCESS_COUNT_EN
    ,
    output logic [15:0]            access_count
`endif
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       mon_q, mon_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;

    cmd_t cmd;
    logic busy;
    logic stalled;
    logic expired;
    logic any_pulse;
    logic done_ok;
    logic unused_jdo;

    assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

    assign busy      = (state_q != ST_IDLE);
    assign stalled   = busy && avm.avm_waitrequest;
    assign done_ok   = busy && !avm.avm_waitrequest;
    assign any_pulse = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    assign cmd = decode_cmd(take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
                            jdo[JDO_WR_BIT], jdo[JDO_RD_AFTER_LOAD_BIT]);

    cpu_debug_mem_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (!stalled),
        .en      (stalled),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        read_d  = read_q;
        write_d = write_q;
        wdata_d = wdata_q;
        mon_d   = mon_q;
        ready_d = ready_q;
        error_d = error_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd.accept) begin
                    error_d = 1'b0;
                    ready_d = !(cmd.start_rd || cmd.start_wr);
                    if (cmd.load_addr) begin
                        addr_d = jdo[ADDR_W+1:JDO_ADDR_LSB];
                    end
                    if (cmd.start_rd) begin
                        state_d = ST_READ;
                        read_d  = 1'b1;
                    end
                    if (cmd.start_wr) begin
                        state_d = ST_WRITE;
                        write_d = 1'b1;
                        wdata_d = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
                    end
                end
            end

            ST_READ, ST_WRITE: begin
                // Commands arriving mid-transfer are dropped but leave a sticky error behind.
                if (any_pulse) begin
                    error_d = 1'b1;
                end
                if (!avm.avm_waitrequest) begin
                    if (state_q == ST_READ) begin
                        mon_d = avm.avm_readdata;
                    end
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ST_IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    ready_d = 1'b1;
                end else if (expired) begin
                    if (state_q == ST_READ) begin
                        mon_d = ERR_DATA;
                    end
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    ready_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            mon_q   <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            mon_q   <= mon_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    assign avm.avm_address    = {addr_q, 2'b00};
    assign avm.avm_read       = read_q;
    assign avm.avm_write      = write_q;
    assign avm.avm_writedata  = wdata_q;
    assign avm.avm_byteenable = 4'hF;

    assign MonDReg       = mon_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

`ifdef CPU_DEBUG_MEM_ACCESS_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (done_ok && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign access_count = count_q;
`else
    logic unused_done_ok;
    assign unused_done_ok = done_ok;
`endif
endmodule

// File: tb/tb_cpu_debug_mem_master.sv
// Self-checking bench: directed scenarios plus randomized commands, checked against a
// transaction-level model of address, MonDReg, ready/error flags and a word-addressed slave memory.
module tb_cpu_debug_mem_master;
    localparam int          ADDR_W = 24;
    localparam int          TO     = 8;
    localparam logic [31:0] ERR    = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        pa, pb, pn;
    logic [31:0] mon;
    logic        rdy, err;
`ifdef CPU_DEBUG_MEM_ACCESS_COUNT_EN
    logic [15:0] access_count;
`endif

    cpu_debug_mem_if #(.ADDR_W(ADDR_W)) avm_bus ();

    cpu_debug_mem_master #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TO),
        .ERR_DATA       (ERR)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (pa),
        .take_action_ocimem_b    (pb),
        .take_no_action_ocimem_a (pn),
        .avm                     (avm_bus),
        .MonDReg                 (mon),
        .monitor_ready           (rdy),
        .monitor_error           (err)
`ifdef CPU_DEBUG_MEM_ACCESS_COUNT_EN
        ,
        .access_count            (access_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model state.
    logic [23:0] m_addr;
    logic [31:0] m_mon;
    logic        m_err;
    logic        m_ready;
    int          m_count;
    logic [31:0] mem [logic [23:0]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return {8'hA5, a};
    endfunction

    task automatic model_reset();
        m_addr  = '0;
        m_mon   = '0;
        m_err   = 1'b0;
        m_ready = 1'b0;
        m_count = 0;
    endtask

    // Issue one command (pulse combination a/b/n with word j), let the slave stall for
    // 'waits' cycles, optionally poke a pulse during the transfer, and check everything.
    task automatic run_cmd(input bit a, input bit b, input bit n, input logic [37:0] j,
                           input int waits, input bit poke);
        int          kind;  // 0 = address load only, 1 = read, 2 = write
        logic [31:0] wdat;
        logic [31:0] rdat;
        bit          done;
        kind = 0;
        if (a) begin
            m_addr = j[25:2];
            kind   = j[34] ? 1 : 0;
        end else if (b) begin
            kind = j[35] ? 2 : 1;
        end else begin
            kind = 1;
        end
        wdat = j[34:3];
        m_err = 1'b0;

        @(negedge clk);
        jdo = j;
        pa  = a;
        pb  = b;
        pn  = n;
        @(negedge clk);
        pa = 1'b0;
        pb = 1'b0;
        pn = 1'b0;

        if (kind == 0) begin
            m_ready = 1'b1;
            check("load_ready", rdy, m_ready);
            check("load_err", err, m_err);
            check("load_noreq", {avm_bus.avm_read, avm_bus.avm_write}, 2'b00);
            return;
        end

        rdat = mem_rd(m_addr);
        done = 1'b0;
        for (int c = 0; !done; c++) begin
            check("req_rd", avm_bus.avm_read, kind == 1);
            check("req_wr", avm_bus.avm_write, kind == 2);
            check("req_addr", avm_bus.avm_address, {m_addr, 2'b00});
            check("busy_ready", rdy, 1'b0);
            if (kind == 2) check("req_wdata", avm_bus.avm_writedata, wdat);
            if (c == 0) begin
                check("req_be", avm_bus.avm_byteenable, 4'hF);
                check("accept_err_clr", err, 1'b0);
                if (poke) pn = 1'b1;
            end
            avm_bus.avm_waitrequest = (c < waits);
            avm_bus.avm_readdata    = (c < waits) ? $urandom : rdat;
            @(negedge clk);
            pn = 1'b0;
            if (c >= waits) begin
                done = 1'b1;
                m_count++;
                if (kind == 1) m_mon = rdat;
                else           mem[m_addr] = wdat;
                m_addr = m_addr + 24'd1;
            end else if (c == TO - 1) begin
                done  = 1'b1;
                m_err = 1'b1;
                if (kind == 1) m_mon = ERR;
            end
        end
        if (poke) m_err = 1'b1;
        avm_bus.avm_waitrequest = 1'b0;
        m_ready = 1'b1;
        check("end_rd", avm_bus.avm_read, 1'b0);
        check("end_wr", avm_bus.avm_write, 1'b0);
        check("end_ready", rdy, m_ready);
        check("end_err", err, m_err);
        check("end_mondreg", mon, m_mon);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rd"}, avm_bus.avm_read, 1'b0);
        check({tag, "_wr"}, avm_bus.avm_write, 1'b0);
        check({tag, "_addr"}, avm_bus.avm_address, '0);
        check({tag, "_wdata"}, avm_bus.avm_writedata, '0);
        check({tag, "_mondreg"}, mon, '0);
        check({tag, "_ready"}, rdy, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        logic [37:0] j;
        logic [2:0]  sel;
        int          w;

        reset = 1'b1;
        jdo   = '0;
        pa    = 1'b0;
        pb    = 1'b0;
        pn    = 1'b0;
        avm_bus.avm_waitrequest = 1'b0;
        avm_bus.avm_readdata    = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b0;

        // Load 0x100 and read with zero wait states.
        mem[24'h000100] = 32'hCAFEF00D;
        j = '0; j[25:2] = 24'h000100; j[34] = 1'b1;
        run_cmd(1, 0, 0, j, 0, 0);

        // Write at 0x101 with three stall cycles; MonDReg must keep the read value.
        j = '0; j[35] = 1'b1; j[34:3] = 32'h12345678;
        run_cmd(0, 1, 0, j, 3, 0);

        // Read-back through ocimem_b at the loaded address.
        j = '0; j[25:2] = 24'h000101;
        run_cmd(1, 0, 0, j, 0, 0);
        j = '0;
        run_cmd(0, 1, 0, j, 1, 0);

        // Address wrap: load all-ones, then four sequential reads.
        j = '0; j[25:2] = 24'hFFFFFF;
        run_cmd(1, 0, 0, j, 0, 0);
        for (int i = 0; i < 4; i++) run_cmd(0, 0, 1, '0, i % 2, 0);

        // Timeout on a read, then the next command clears the error and reuses the address.
        run_cmd(0, 0, 1, '0, TO, 0);
        run_cmd(0, 0, 1, '0, 0, 0);

        // Pulse during a busy read, then simultaneous a+b in idle.
        run_cmd(0, 0, 1, '0, 2, 1);
        j = '0; j[25:2] = 24'h00ABCD; j[35] = 1'b1;
        run_cmd(1, 1, 0, j, 0, 0);
        run_cmd(0, 0, 1, '0, 0, 0);

        // Reset in the middle of a stalled write.
        @(negedge clk);
        j = '0; j[35] = 1'b1; j[34:3] = 32'h0BADF00D;
        jdo = j;
        pb  = 1'b1;
        @(negedge clk);
        pb = 1'b0;
        avm_bus.avm_waitrequest = 1'b1;
        check("midwr_req", avm_bus.avm_write, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midwr_rst");
        reset = 1'b0;
        avm_bus.avm_waitrequest = 1'b0;
        model_reset();

        // Three good operations plus one timeout.
        run_cmd(0, 0, 1, '0, 0, 0);
        j = '0; j[35] = 1'b1; j[34:3] = 32'h55AA55AA;
        run_cmd(0, 1, 0, j, 2, 0);
        run_cmd(0, 0, 1, '0, 1, 0);
        run_cmd(0, 0, 1, '0, TO + 1, 0);
`ifdef CPU_DEBUG_MEM_ACCESS_COUNT_EN
        check("access_count_3", access_count, 16'(m_count));
`endif

        // Randomized command mix.
        for (int i = 0; i < 60; i++) begin
            sel = 3'($urandom_range(1, 7));
            j   = 38'({$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) j[25:2] = 24'hFFFFFF - 24'($urandom_range(0, 2));
            w = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, 3);
            run_cmd(sel[0], sel[1], sel[2], j, w, $urandom_range(0, 7) == 0);
        end
`ifdef CPU_DEBUG_MEM_ACCESS_COUNT_EN
        check("access_count_end", access_count, 16'(m_count));
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_debug_mem_master.md
Name: cpu_debug_mem_master

Overview:
Downstream consumer of the debug slave sysclk-side outputs (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a). Decodes JTAG monitor memory commands and runs single-word Avalon-MM master reads and writes with an auto-incrementing word address. Returns MonDReg, monitor_ready and monitor_error, which feed back into the debug slave wrapper's capture inputs.

Parameters:
ADDR_W, 24, word-address width; avm_address = {addr, 2'b00}
TIMEOUT_CYCLES, 1023, max consecutive waitrequest cycles before abort; range 1..65535
ERR_DATA, 32'hDEADBEEF, MonDReg value loaded on timeout

Ports:
clk  in  1  system clock, same as debug slave sysclk side
reset  in  1  synchronous, active-high
jdo  in  38  debug data word from debug slave
take_action_ocimem_a  in  1  1-cycle pulse: load address
take_action_ocimem_b  in  1  1-cycle pulse: write or read at current address
take_no_action_ocimem_a  in  1  1-cycle pulse: sequential read at current address
avm_address  out  ADDR_W+2  byte address
avm_read  out  1  read request
avm_write  out  1  write request
avm_writedata  out  32  write data
avm_byteenable  out  4  constant 4'hF
avm_readdata  in  32  read data, valid when avm_read && !avm_waitrequest
avm_waitrequest  in  1  slave stall
MonDReg  out  32  last read data (or ERR_DATA after a timeout)
monitor_ready  out  1  high when idle and last command finished
monitor_error  out  1  sticky error flag

Behaviour:
- Clock/reset as decided: single clock clk; reset synchronous, active-high.
- Reset values: avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, MonDReg=0, monitor_ready=0, monitor_error=0, addr=0, FSM=IDLE.
- Command decode, sampled only in IDLE on the pulse cycle:
  - ocimem_a: addr <= jdo[ADDR_W+1:2]. If jdo[34]=1, start READ. Otherwise stay IDLE with monitor_ready=1.
  - ocimem_b with jdo[35]=1: start WRITE, avm_writedata <= jdo[34:3].
  - ocimem_b with jdo[35]=0: start READ.
  - no_action_ocimem_a: start READ.
- Priority for simultaneous pulses: ocimem_a > ocimem_b > no_action_ocimem_a. The losers are ignored with no error.
- Accepting any command clears monitor_ready and monitor_error on the next edge.
- FSM states IDLE, READ, WRITE.
  - IDLE→READ/WRITE: request asserted the cycle after the pulse.
  - READ completes when avm_waitrequest=0. Then MonDReg <= avm_readdata, addr <= addr+1, →IDLE, monitor_ready=1.
  - WRITE completes when avm_waitrequest=0. Then addr <= addr+1, →IDLE, monitor_ready=1. MonDReg is unchanged.
- Latency: pulse at cycle N, request high at N+1. With zero wait states, monitor_ready=1 and MonDReg valid at N+2.
- Address wraps modulo 2^ADDR_W (all-ones +1 → 0), with no flag.
- Timeout: a 16-bit counter tracks consecutive waitrequest cycles. When it reaches TIMEOUT_CYCLES:
  - drop the request; addr is not incremented
  - MonDReg <= ERR_DATA on reads
  - monitor_error=1, monitor_ready=1, →IDLE
- Busy drop: a command pulse arriving in READ/WRITE is discarded and sets monitor_error=1 (sticky). The in-flight transaction continues and completes normally.
- Reset mid-transaction: request drops on the next edge; everything returns to reset values.
- Request outputs are registered and held stable while avm_waitrequest=1 (Avalon rule).

Optional Feature:
Macro CPU_DEBUG_MEM_ACCESS_COUNT_EN.
- Defined: adds output access_count [15:0], a saturating count (stops at 16'hFFFF) of successfully completed reads and writes. Timeouts and drops are not counted. Reset value 0.
- Undefined: no port and no counter logic.

Decomposition:
- Package cpu_debug_mem_pkg holds:
  - the FSM state enum
  - jdo field constants (JDO_WR_BIT=35, JDO_RD_AFTER_LOAD_BIT=34, JDO_DATA_MSB=34, JDO_DATA_LSB=3)
  - the default ERR_DATA
- One sub-module, cpu_debug_mem_timeout: loadable 16-bit wait counter with clear, enable and expired output.

Test Plan:
- ocimem_a with jdo[ADDR_W+1:2]=24'h000100, jdo[34]=1; slave returns 32'hCAFEF00D with 0 wait → avm_address=26'h400 at N+1, MonDReg=32'hCAFEF00D and monitor_ready=1 at N+2, addr=24'h000101.
- ocimem_b with jdo[35]=1, jdo[34:3]=32'h12345678; waitrequest high for 3 cycles → avm_write held 4 cycles with data stable, monitor_ready at N+5, MonDReg unchanged.
- ocimem_a to 24'hFFFFFF, then four no_action_ocimem_a reads → addresses FFFFFF, 000000, 000001, 000002.
- TIMEOUT_CYCLES=8, waitrequest stuck high on a read → request drops after 8 cycles, MonDReg=32'hDEADBEEF, monitor_error=1, addr not incremented. The next command clears monitor_error.
- Pulse during a busy read → monitor_error=1, the original read completes with correct MonDReg. Simultaneous a+b pulses in IDLE → only the address load occurs.
- Reset asserted mid-write → avm_write=0 next edge, all outputs at reset values. With CPU_DEBUG_MEM_ACCESS_COUNT_EN, 3 good ops plus 1 timeout → access_count=3.
